regfile_mp: RTL and testbench



---
 rtl/regfile_pkg.sv | 35 +++
 rtl/regfile_rd_port.sv | 53 +++++
 rtl/regfile_mp.sv | 100 ++++++++++
 tb/tb_regfile_mp.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the multi-port register file.
package regfile_pkg;

  localparam int DW_DEF    = 32;
  localparam int NREGS_DEF = 32;
  localparam int NR_DEF    = 2;
  localparam int NW_DEF    = 1;
  localparam int ZERO_ADDR = 0;

  localparam int MAX_NW = 8;
  localparam int MAX_AW = 16;

  typedef struct packed {
    logic       hit;
    logic [2:0] idx;
  } wr_res_t;

  // Highest-index matching write port wins.
  function automatic wr_res_t wr_resolve(
    input logic [MAX_NW-1:0]        en,
    input logic [MAX_NW*MAX_AW-1:0] addr,
    input logic [MAX_AW-1:0]        tgt
  );
    wr_res_t res;
    res = '0;
    for (int j = 0; j < MAX_NW; j++) begin
      if (en[j] && addr[j*MAX_AW +: MAX_AW] == tgt) begin
        res.hit = 1'b1;
        res.idx = 3'(j);
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// One registered read port: bypass/zero select plus output registers.
module regfile_rd_port
  import regfile_pkg::*;
#(
  parameter int DW       = DW_DEF,
  parameter int AW       = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] old_i,
  input  logic [DW-1:0] new_i,
  input  logic          pend_i,
  output logic [DW-1:0] data_o,
  output logic          pend_o
);

  logic [DW-1:0] data_q, data_d;
  logic          pend_q, pend_d;
  logic          is_zero;

  assign is_zero = (ZERO_REG != 0) && (addr_i == AW'(ZERO_ADDR));

  always_comb begin
    data_d = data_q;
    pend_d = pend_q;
    if (en_i) begin
      data_d = (BYPASS != 0) ? new_i : old_i;
      pend_d = pend_i;
      if (is_zero) begin
        data_d = '0;
        pend_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q <= '0;
      pend_q <= 1'b0;
    end else begin
      data_q <= data_d;
      pend_q <= pend_d;
    end
  end

  assign data_o = data_q;
  assign pend_o = pend_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with hardwired zero and pending scoreboard.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DW       = DW_DEF,
  parameter int NREGS    = NREGS_DEF,
  parameter int AW       = $clog2(NREGS),
  parameter int NR       = NR_DEF,
  parameter int NW       = NW_DEF,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NR-1:0]    rd_en,
  input  logic [NR*AW-1:0] rd_addr,
  output logic [NR*DW-1:0] rd_data,
  output logic [NR-1:0]    rd_pending,
  input  logic [NW-1:0]    wr_en,
  input  logic [NW*AW-1:0] wr_addr,
  input  logic [NW*DW-1:0] wr_data,
  input  logic             rsv_en,
  input  logic [AW-1:0]    rsv_addr,
  output logic [NREGS-1:0] pend_vec
);

  logic [DW-1:0]    regs_q [NREGS];
  logic [DW-1:0]    regs_d [NREGS];
  logic [NREGS-1:0] pend_q, pend_d;

  logic [MAX_NW-1:0]        en_pad;
  logic [MAX_NW*MAX_AW-1:0] wa_pad;

  always_comb begin
    en_pad = '0;
    wa_pad = '0;
    en_pad[NW-1:0] = wr_en;
    for (int j = 0; j < NW; j++) begin
      wa_pad[j*MAX_AW +: MAX_AW] = MAX_AW'(wr_addr[j*AW +: AW]);
    end
  end

  // Reserve overrides retirement so a newer producer stays visible.
  always_comb begin
    wr_res_t res;
    logic    zr;
    for (int r = 0; r < NREGS; r++) begin
      res       = wr_resolve(en_pad, wa_pad, MAX_AW'(r));
      zr        = (ZERO_REG != 0) && (r == ZERO_ADDR);
      regs_d[r] = regs_q[r];
      pend_d[r] = pend_q[r];
      if (res.hit && !zr) begin
        regs_d[r] = wr_data[int'(res.idx)*DW +: DW];
      end
      if (rsv_en && rsv_addr == AW'(r)) begin
        pend_d[r] = 1'b1;
      end else if (res.hit) begin
        pend_d[r] = 1'b0;
      end
      if (zr) begin
        pend_d[r] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      regs_q <= '{default: '0};
      pend_q <= '0;
    end else begin
      regs_q <= regs_d;
      pend_q <= pend_d;
    end
  end

  assign pend_vec = pend_q;

  for (genvar k = 0; k < NR; k++) begin : g_rd
    logic [AW-1:0] a;
    assign a = rd_addr[k*AW +: AW];

    regfile_rd_port #(
      .DW       (DW),
      .AW       (AW),
      .ZERO_REG (ZERO_REG),
      .BYPASS   (BYPASS)
    ) u_port (
      .clk    (clk),
      .reset  (reset),
      .en_i   (rd_en[k]),
      .addr_i (a),
      .old_i  (regs_q[a]),
      .new_i  (regs_d[a]),
      .pend_i (pend_d[a]),
      .data_o (rd_data[k*DW +: DW]),
      .pend_o (rd_pending[k])
    );
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench: two regfile_mp instances (write-first and read-first) vs a model.
module tb_regfile_mp;

  localparam int DW = 32;
  localparam int NREGS = 32;
  localparam int AW = 5;
  localparam int NR = 3;
  localparam int NW = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic [NR-1:0]    rd_en;
  logic [NR*AW-1:0] rd_addr;
  logic [NW-1:0]    wr_en;
  logic [NW*AW-1:0] wr_addr;
  logic [NW*DW-1:0] wr_data;
  logic             rsv_en;
  logic [AW-1:0]    rsv_addr;

  logic [NR*DW-1:0] rdat1, rdat0;
  logic [NR-1:0]    rpen1, rpen0;
  logic [NREGS-1:0] pv1, pv0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_mp #(
    .DW(DW), .NREGS(NREGS), .NR(NR), .NW(NW),
    .ZERO_REG(1), .BYPASS(1)
  ) dut_wf (
    .clk(clk), .reset(reset),
    .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rdat1), .rd_pending(rpen1),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .pend_vec(pv1)
  );

  regfile_mp #(
    .DW(DW), .NREGS(NREGS), .NR(NR), .NW(NW),
    .ZERO_REG(1), .BYPASS(0)
  ) dut_rf (
    .clk(clk), .reset(reset),
    .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rdat0), .rd_pending(rpen0),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .pend_vec(pv0)
  );

  // Behavioural model: sequential program per edge
  logic [DW-1:0] m_reg [NREGS];
  logic [DW-1:0] m_old [NREGS];
  bit            m_pend [NREGS];
  logic [DW-1:0] e_wf [NR];
  logic [DW-1:0] e_rf [NR];
  bit            e_p [NR];
  bit            live = 0;

  always @(posedge clk) begin
    int a;
    if (reset) begin
      for (int r = 0; r < NREGS; r++) begin
        m_reg[r] = 0;
        m_pend[r] = 0;
      end
      for (int k = 0; k < NR; k++) begin
        e_wf[k] = 0;
        e_rf[k] = 0;
        e_p[k] = 0;
      end
      live = 1;
    end else begin
      m_old = m_reg;
      for (int j = 0; j < NW; j++) begin
        a = int'(wr_addr[j*AW +: AW]);
        if (wr_en[j]) begin
          if (a != 0) m_reg[a] = wr_data[j*DW +: DW];
          m_pend[a] = 0;
        end
      end
      if (rsv_en && rsv_addr != 0) m_pend[rsv_addr] = 1;
      for (int k = 0; k < NR; k++) begin
        a = int'(rd_addr[k*AW +: AW]);
        if (rd_en[k]) begin
          e_wf[k] = (a == 0) ? 0 : m_reg[a];
          e_rf[k] = (a == 0) ? 0 : m_old[a];
          e_p[k] = m_pend[a];
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [NREGS-1:0] mv;
    if (live) begin
      for (int r = 0; r < NREGS; r++) mv[r] = m_pend[r];
      chk("pend_vec_wf", 64'(pv1), 64'(mv));
      chk("pend_vec_rf", 64'(pv0), 64'(mv));
      for (int k = 0; k < NR; k++) begin
        chk($sformatf("rd_data_wf[%0d]", k), 64'(rdat1[k*DW +: DW]), 64'(e_wf[k]));
        chk($sformatf("rd_data_rf[%0d]", k), 64'(rdat0[k*DW +: DW]), 64'(e_rf[k]));
        chk($sformatf("rd_pend_wf[%0d]", k), 64'(rpen1[k]), 64'(e_p[k]));
        chk($sformatf("rd_pend_rf[%0d]", k), 64'(rpen0[k]), 64'(e_p[k]));
      end
    end
  end

  task automatic idle();
    rd_en = '0;
    wr_en = '0;
    rsv_en = 1'b0;
  endtask

  task automatic tick();
    @(negedge clk);
    idle();
  endtask

  task automatic wr(input int p, input int a, input logic [DW-1:0] d);
    wr_en[p] = 1'b1;
    wr_addr[p*AW +: AW] = AW'(a);
    wr_data[p*DW +: DW] = d;
  endtask

  task automatic rd(input int p, input int a);
    rd_en[p] = 1'b1;
    rd_addr[p*AW +: AW] = AW'(a);
  endtask

  task automatic rsv(input int a);
    rsv_en = 1'b1;
    rsv_addr = AW'(a);
  endtask

  function automatic logic [DW-1:0] d1(input int p);
    return rdat1[p*DW +: DW];
  endfunction

  function automatic logic [DW-1:0] d0(input int p);
    return rdat0[p*DW +: DW];
  endfunction

  initial begin
    reset = 1'b1;
    rd_addr = '0;
    wr_addr = '0;
    wr_data = '0;
    rsv_addr = '0;
    idle();
    tick();
    tick();
    chk("lit_reset_pv", 64'(pv1), 64'd0);
    chk("lit_reset_rd", 64'(d1(0)), 64'd0);

    // reset clears storage
    reset = 1'b0;
    wr(0, 5, 32'hDEADBEEF);
    tick();
    rd(0, 5);
    tick();
    chk("lit_r5_before_rst", 64'(d0(0)), 64'hDEADBEEF);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    rd(0, 5);
    tick();
    chk("lit_r5_after_rst", 64'(d1(0)), 64'd0);
    tick();
    chk("lit_hold_zero", 64'(d1(0)), 64'd0);

    // bypass vs read-first
    wr(0, 7, 32'h12345678);
    rd(0, 7);
    tick();
    chk("lit_bypass_wf", 64'(d1(0)), 64'h12345678);
    chk("lit_bypass_rf", 64'(d0(0)), 64'd0);

    // zero register
    wr(1, 0, 32'hFFFFFFFF);
    rsv(0);
    rd(0, 0); rd(1, 0); rd(2, 0);
    tick();
    chk("lit_zero_rd", 64'(d1(1)), 64'd0);
    chk("lit_zero_pend", 64'(rpen1), 64'd0);
    chk("lit_zero_pv0", 64'(pv1[0]), 64'd0);
    rd(0, 0); rd(1, 0);
    tick();

    // write-port conflict
    wr(0, 3, 32'h0000AAAA);
    wr(1, 3, 32'h00005555);
    tick();
    rd(1, 3);
    tick();
    chk("lit_conflict", 64'(d0(1)), 64'h5555);

    // scoreboard
    rsv(9);
    rd(2, 9);
    tick();
    chk("lit_rsv_pv", 64'(pv1[9]), 64'd1);
    chk("lit_rsv_rdpend", 64'(rpen0[2]), 64'd1);
    wr(0, 9, 32'h1);
    rsv(9);
    tick();
    chk("lit_rsv_beats_wr", 64'(pv0[9]), 64'd1);
    wr(1, 9, 32'h77);
    tick();
    chk("lit_wr_clears", 64'(pv1[9]), 64'd0);
    rd(0, 9);
    tick();
    chk("lit_r9_data", 64'(d0(0)), 64'h77);

    // hold / independence
    wr(0, 1, 32'h11);
    wr(1, 2, 32'h22);
    tick();
    wr(0, 4, 32'h44);
    tick();
    rd(1, 4);
    tick();
    rd(0, 1); rd(1, 2); rd(2, 1);
    rd_en[1] = 1'b0;
    tick();
    chk("lit_hold_p0", 64'(d1(0)), 64'h11);
    chk("lit_hold_p1", 64'(d1(1)), 64'h44);
    chk("lit_hold_p2", 64'(d1(2)), 64'h11);

    // reset discards in-flight write and reserve
    wr(0, 10, 32'hCAFE);
    rsv(11);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    rd(0, 10);
    tick();
    chk("lit_midrst_data", 64'(d1(0)), 64'd0);
    chk("lit_midrst_pv", 64'(pv1), 64'd0);

    // mixed traffic checked by the model
    for (int i = 0; i < 60; i++) begin
      wr_en = NW'($urandom);
      for (int j = 0; j < NW; j++) begin
        wr_addr[j*AW +: AW] = AW'($urandom_range(0, 7));
        wr_data[j*DW +: DW] = $urandom;
      end
      rsv_en = 1'($urandom);
      rsv_addr = AW'($urandom_range(0, 7));
      rd_en = NR'($urandom);
      for (int k = 0; k < NR; k++) begin
        rd_addr[k*AW +: AW] = AW'($urandom_range(0, 7));
      end
      @(negedge clk);
    end
    idle();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
